oam_dma_master: RTL and testbench

- Game Boy OAM DMA engine. It is the bus initiator counterpart to the memory responders on the shared address/data/nread/nwrite bus.
- It snoops CPU writes to the DMA register (FF46), requests the bus from the core, and copies LENGTH bytes from {src_hi,8'h00} to DEST_BASE.
- Each byte is a read cycle followed by a write cycle, with the same strobe semantics the core uses.
- It sits in the interconnect beside core and the memory responders. The core tri-states its bus outputs while bus_grant is high.

---
 rtl/oam_dma_master_pkg.sv | 25 ++
 rtl/oam_dma_master_reg_snoop.sv | 43 ++++
 rtl/oam_dma_master.sv | 136 +++++++++++++
 tb/tb_oam_dma_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_master_pkg.sv
// Shared definitions for the OAM DMA initiator: FSM encoding, default
// register/destination addresses and the idle level of the bus strobes.
package oam_dma_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_DONE
   } dma_state_t;

   localparam int          LENGTH_DEFAULT    = 160;
   localparam logic [15:0] REG_ADDR_DEFAULT  = 16'hFF46;
   localparam logic [15:0] DEST_BASE_DEFAULT = 16'hFE00;
   localparam logic        STROBE_IDLE       = 1'b1;

   // Pages E0..FF are the echo of C0..DF.
   function automatic logic [7:0] echo_map(input logic [7:0] page);
      return (page >= 8'hE0) ? page - 8'h20 : page;
   endfunction

endpackage

// File: rtl/oam_dma_master_reg_snoop.sv
// Snoops core writes to the DMA register: holds the readback value, the
// echo-mapped source page, and a one-cycle start pulse for the FSM.
module oam_dma_master_reg_snoop
   import oam_dma_master_pkg::*;
#(
   parameter logic [15:0] REG_ADDR = REG_ADDR_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_nwrite,
   output logic [7:0]  reg_rdata,
   output logic [7:0]  src_hi,
   output logic        start
);

   logic [7:0] reg_rdata_reg;
   logic [7:0] src_hi_reg;
   logic       start_reg;
   logic       hit;

   assign hit = !cpu_nwrite && (cpu_address == REG_ADDR);

   always_ff @(posedge clock) begin
      if (reset) begin
         reg_rdata_reg <= 8'h00;
         src_hi_reg    <= 8'h00;
         start_reg     <= 1'b0;
      end else begin
         start_reg <= hit;
         if (hit) begin
            reg_rdata_reg <= cpu_wdata;
            src_hi_reg    <= echo_map(cpu_wdata);
         end
      end
   end

   assign reg_rdata = reg_rdata_reg;
   assign src_hi    = src_hi_reg;
   assign start     = start_reg;

endmodule

// File: rtl/oam_dma_master.sv
// OAM DMA bus initiator: copies LENGTH bytes from {src_hi,8'h00} to DEST_BASE,
// one read cycle pair and one write cycle pair per byte, while granted the bus.
module oam_dma_master
   import oam_dma_master_pkg::*;
#(
   parameter int          LENGTH    = LENGTH_DEFAULT,
   parameter logic [15:0] DEST_BASE = DEST_BASE_DEFAULT,
   parameter logic [15:0] REG_ADDR  = REG_ADDR_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_nwrite,
   output logic [7:0]  reg_rdata,
   output logic        bus_req,
   input  logic        bus_grant,
   output logic [15:0] address_bus,
   inout  wire  [7:0]  data_bus,
   output logic        nread,
   output logic        nwrite,
   output logic        busy
);

   localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

   dma_state_t  state_reg, state_next;
   logic [7:0]  index_reg, index_next;
   logic [7:0]  latch_reg, latch_next;
   logic [7:0]  src_hi;
   logic        start;
   logic        drive_bus;
   logic        drive_data;
   logic [15:0] addr_out;
   logic        nread_out;
   logic        nwrite_out;

   oam_dma_master_reg_snoop #(
      .REG_ADDR (REG_ADDR)
   ) u_snoop (
      .clock       (clock),
      .reset       (reset),
      .cpu_address (cpu_address),
      .cpu_wdata   (cpu_wdata),
      .cpu_nwrite  (cpu_nwrite),
      .reg_rdata   (reg_rdata),
      .src_hi      (src_hi),
      .start       (start)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         index_reg <= 8'h00;
         latch_reg <= 8'h00;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         latch_reg <= latch_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      latch_next = latch_reg;
      bus_req    = 1'b0;
      drive_bus  = 1'b0;
      drive_data = 1'b0;
      addr_out   = {src_hi, index_reg};
      nread_out  = STROBE_IDLE;
      nwrite_out = STROBE_IDLE;

      case (state_reg)
         ST_IDLE: ;
         ST_REQ: begin
            bus_req = 1'b1;
            if (bus_grant) state_next = ST_RD_ADDR;
         end
         ST_RD_ADDR, ST_RD_DATA: begin
            bus_req = 1'b1;
            // Losing the grant freezes index/latch; the byte is re-read later.
            if (!bus_grant) begin
               state_next = ST_REQ;
            end else begin
               drive_bus = 1'b1;
               nread_out = 1'b0;
               if (state_reg == ST_RD_ADDR) begin
                  state_next = ST_RD_DATA;
               end else begin
                  latch_next = data_bus;
                  state_next = ST_WR_ADDR;
               end
            end
         end
         ST_WR_ADDR, ST_WR_DATA: begin
            bus_req = 1'b1;
            if (!bus_grant) begin
               state_next = ST_REQ;
            end else begin
               drive_bus  = 1'b1;
               drive_data = 1'b1;
               addr_out   = DEST_BASE + {8'h00, index_reg};
               nwrite_out = 1'b0;
               if (state_reg == ST_WR_ADDR) begin
                  state_next = ST_WR_DATA;
               end else if (index_reg == LAST_INDEX) begin
                  state_next = ST_DONE;
               end else begin
                  index_next = index_reg + 8'd1;
                  state_next = ST_RD_ADDR;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      // A fresh register write restarts from byte 0 and drops this cycle's strobe.
      if (start) begin
         state_next = ST_REQ;
         index_next = 8'h00;
         latch_next = latch_reg;
         drive_bus  = 1'b0;
         drive_data = 1'b0;
      end
   end

   // busy spans DONE so it drops the cycle after the bus has been handed back.
   assign busy        = (state_reg != ST_IDLE);
   assign address_bus = drive_bus  ? addr_out   : 16'hzzzz;
   assign nread       = drive_bus  ? nread_out  : 1'bz;
   assign nwrite      = drive_bus  ? nwrite_out : 1'bz;
   assign data_bus    = drive_data ? latch_reg  : 8'hzz;

endmodule

// File: tb/tb_oam_dma_master.sv
// Directed/randomised bench for oam_dma_master with a behavioural memory on the
// shared bus; released bus lines are pulled high so a release reads as all ones.
`timescale 1ns/1ps
module tb_oam_dma_master;

   localparam int          LENGTH = 160;
   localparam logic [15:0] DEST   = 16'hFE00;
   localparam logic [15:0] REG    = 16'hFF46;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cpu_address = 16'h0000;
   logic [7:0]  cpu_wdata = 8'h00;
   logic        cpu_nwrite = 1'b1;
   logic        bus_grant = 1'b1;
   logic [7:0]  reg_rdata;
   logic        bus_req;
   logic        busy;
   tri1  [15:0] address_bus;
   tri1  [7:0]  data_bus;
   tri1         nread;
   tri1         nwrite;

   oam_dma_master #(.LENGTH(LENGTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_address (cpu_address),
      .cpu_wdata   (cpu_wdata),
      .cpu_nwrite  (cpu_nwrite),
      .reg_rdata   (reg_rdata),
      .bus_req     (bus_req),
      .bus_grant   (bus_grant),
      .address_bus (address_bus),
      .data_bus    (data_bus),
      .nread       (nread),
      .nwrite      (nwrite),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   // Source memory is preset by the stimulus; destination writes are logged
   // separately with the generation number of the transfer that made them.
   logic [7:0] src_mem  [0:65535];
   logic [7:0] dest_mem [0:255];
   int         dest_gen [0:255];
   int         cur_gen = 0;
   int         outside_writes = 0;
   int         fe14_writes = 0;
   int         both_low = 0;

   assign data_bus = (nread == 1'b0) ? src_mem[address_bus] : 8'hzz;

   always @(posedge clock) begin
      if (nread === 1'b0 && nwrite === 1'b0) both_low <= both_low + 1;
      if (nwrite === 1'b0) begin
         if (address_bus[15:8] == DEST[15:8] && int'(address_bus[7:0]) < LENGTH) begin
            dest_mem[address_bus[7:0]] <= data_bus;
            dest_gen[address_bus[7:0]] <= cur_gen;
         end else begin
            outside_writes <= outside_writes + 1;
         end
         if (address_bus == DEST + 16'd20) fe14_writes <= fe14_writes + 1;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: the byte for destination i comes from page*256+i, with pages
   // E0..FF folded down by 0x2000.
   function automatic int src_base(input logic [7:0] page);
      int b;
      b = int'(page) * 256;
      if (b >= 'hE000) b = b - 'h2000;
      return b;
   endfunction

   task automatic check_image(input string tag, input logic [7:0] page);
      int bad = 0;
      int base;
      base = src_base(page);
      for (int i = 0; i < LENGTH; i++)
         if (dest_gen[i] !== cur_gen || dest_mem[i] !== src_mem[base + i]) bad++;
      check({tag, "_image_bad_bytes"}, 32'(bad), 32'd0);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock);
      cpu_address = a;
      cpu_wdata   = d;
      cpu_nwrite  = 1'b0;
      @(negedge clock);
      cpu_nwrite  = 1'b1;
      cpu_address = 16'h0000;
   endtask

   // Called at the first negedge after the trigger edge; returns the number of
   // clock edges from the trigger edge to the edge where busy fell.
   task automatic wait_done(input string tag, output int latency);
      int n = 1;
      bit seen = 1'b0;
      latency = -1;
      while (n < 4000) begin
         @(negedge clock);
         n++;
         if (busy) seen = 1'b1;
         else if (seen) begin
            latency = n - 1;
            break;
         end
      end
      if (latency < 0) check({tag, "_busy_timeout"}, 32'(n), 32'd0);
   endtask

   task automatic wait_strobe(input string tag, input bit is_write, input logic [15:0] a);
      int n = 0;
      while (n < 3000) begin
         @(negedge clock);
         if ((is_write ? nwrite : nread) === 1'b0 && address_bus === a) break;
         n++;
      end
      if (n >= 3000) check({tag, "_strobe_timeout"}, 32'(n), 32'd0);
   endtask

   task automatic first_read(input string tag, output logic [15:0] a);
      int n = 0;
      a = 16'h0000;
      while (n < 3000) begin
         if (nread === 1'b0) begin
            a = address_bus;
            break;
         end
         @(negedge clock);
         n++;
      end
      if (n >= 3000) check({tag, "_read_timeout"}, 32'(n), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          bad;
      int          outside0;
      int          both0;
      int          fe14_0;
      logic [7:0]  pg;
      logic [7:0]  saved14;
      logic [15:0] ra;

      for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
      for (int i = 0; i < LENGTH; i++) src_mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

      // Reset, then idle
      repeat (3) @(negedge clock);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (busy !== 1'b0 || bus_req !== 1'b0 || nread !== 1'b1 || nwrite !== 1'b1) bad++;
      end
      check("idle_violations", 32'(bad), 32'd0);
      check("idle_bus_req", 32'(bus_req), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_reg_rdata", 32'(reg_rdata), 32'h00);
      check("idle_address_released", 32'(address_bus), 32'hFFFF);
      check("idle_data_released", 32'(data_bus), 32'hFF);
      check("idle_nread_released", 32'(nread), 32'd1);
      check("idle_nwrite_released", 32'(nwrite), 32'd1);
      $display("idle: busy=%0d bus_req=%0d reg_rdata=%02h", busy, bus_req, reg_rdata);

      // Plain copy from C100 with grant held
      outside0 = outside_writes; both0 = both_low;
      cur_gen++;
      cpu_write(REG, 8'hC1);
      wait_done("c1", lat);
      check("c1_latency", 32'(lat), 32'(LENGTH * 4 + 3));
      check_image("c1", 8'hC1);
      check("c1_reg_rdata", 32'(reg_rdata), 32'hC1);
      check("c1_outside_writes", 32'(outside_writes - outside0), 32'd0);
      check("c1_both_strobes_low", 32'(both_low - both0), 32'd0);
      $display("transfer src=C1 latency=%0d reg_rdata=%02h", lat, reg_rdata);

      // Echo page E1 reads C100
      cur_gen++;
      cpu_write(REG, 8'hE1);
      wait_done("e1", lat);
      check("e1_latency", 32'(lat), 32'(LENGTH * 4 + 3));
      check_image("e1", 8'hE1);
      check("e1_reg_rdata", 32'(reg_rdata), 32'hE1);
      $display("transfer src=E1 latency=%0d reg_rdata=%02h", lat, reg_rdata);

      // Grant dropped for 5 cycles during the write of byte 7
      pg = 8'($urandom_range(8'h80, 8'hBF));
      outside0 = outside_writes; both0 = both_low;
      cur_gen++;
      cpu_write(REG, pg);
      wait_strobe("grant", 1'b1, DEST + 16'd7);
      @(negedge clock);
      bus_grant = 1'b0;
      #1;
      check("grant_nwrite_released", 32'(nwrite), 32'd1);
      check("grant_address_released", 32'(address_bus), 32'hFFFF);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (nread !== 1'b1 || nwrite !== 1'b1 || address_bus !== 16'hFFFF || data_bus !== 8'hFF) bad++;
      end
      check("grant_hold_released", 32'(bad), 32'd0);
      bus_grant = 1'b1;
      first_read("grant", ra);
      check("grant_reread_address", 32'(ra), 32'(src_base(pg) + 7));
      wait_done("grant", lat);
      check_image("grant", pg);
      check("grant_outside_writes", 32'(outside_writes - outside0), 32'd0);
      check("grant_both_strobes_low", 32'(both_low - both0), 32'd0);
      $display("transfer src=%02h grant drop at index 7 reread=%04h", pg, ra);

      // Re-trigger with D0 at index 40
      pg = 8'($urandom_range(8'h40, 8'h7F));
      cpu_write(REG, pg);
      wait_strobe("retrig", 1'b0, 16'(src_base(pg) + 40));
      cur_gen++;
      cpu_write(REG, 8'hD0);
      first_read("retrig", ra);
      check("retrig_first_read", 32'(ra), 32'hD000);
      wait_done("retrig", lat);
      check_image("retrig", 8'hD0);
      check("retrig_reg_rdata", 32'(reg_rdata), 32'hD0);
      $display("transfer src=%02h restarted with D0 first_read=%04h", pg, ra);

      // Reset while reading byte 20
      pg = 8'($urandom_range(8'h10, 8'h3F));
      saved14 = dest_mem[20];
      cur_gen++;
      cpu_write(REG, pg);
      wait_strobe("rst", 1'b0, 16'(src_base(pg) + 20));
      reset = 1'b1;
      fe14_0 = fe14_writes;
      @(posedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_nread_released", 32'(nread), 32'd1);
      check("rst_nwrite_released", 32'(nwrite), 32'd1);
      check("rst_address_released", 32'(address_bus), 32'hFFFF);
      check("rst_reg_rdata", 32'(reg_rdata), 32'h00);
      @(negedge clock);
      reset = 1'b0;
      repeat (30) @(negedge clock);
      check("rst_fe14_writes", 32'(fe14_writes - fe14_0), 32'd0);
      check("rst_fe14_value", 32'(dest_mem[20]), 32'(saved14));
      check("rst_busy_after", 32'(busy), 32'd0);
      $display("transfer src=%02h reset at index 20 busy=%0d", pg, busy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
